// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit
// Description : Register-file writer. Tracks outstanding data-memory loads in
//               an in-order queue, formats returning load data by funct3 and
//               byte offset, and arbitrates the single register-file write
//               port between load responses, a one-entry ALU skid buffer and
//               live ALU results. Flags read-after-load hazards to decode.
// Ports       : clock/reset      - clock, synchronous active-low reset
//               alu_*            - ALU result handshake (alu_ready out)
//               ld_*             - load issue into the queue (ld_ready out)
//               mem_rvalid/rdata - in-order load responses
//               rs1/rs2, hazard  - decode hazard check against pending loads
//               regwrite, write_reg, write_data - register-file write port
//               err              - sticky: [0] orphan response, [1] bad load
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit #(
    parameter int LDQ_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_result,
    output logic        alu_ready,
    input  logic        ld_issue,
    input  logic [4:0]  ld_rd,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    output logic        ld_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        hazard,
    output logic        regwrite,
    output logic [4:0]  write_reg,
    output logic [31:0] write_data,
    output logic [1:0]  err
);

    localparam int c_ptr_w = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
    localparam int c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_full_count = c_cnt_w'(LDQ_DEPTH);

    localparam logic [2:0] c_lb  = 3'b000;
    localparam logic [2:0] c_lh  = 3'b001;
    localparam logic [2:0] c_lw  = 3'b010;
    localparam logic [2:0] c_lbu = 3'b100;
    localparam logic [2:0] c_lhu = 3'b101;

    // Load queue storage and pointers
    logic [4:0]         r_q_rd  [LDQ_DEPTH];
    logic [2:0]         r_q_f3  [LDQ_DEPTH];
    logic [1:0]         r_q_off [LDQ_DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    // Skid buffer for an ALU result that lost arbitration
    logic               r_skid_valid;
    logic [4:0]         r_skid_rd;
    logic [31:0]        r_skid_data;

    logic               r_regwrite;
    logic [4:0]         r_write_reg;
    logic [31:0]        r_write_data;
    logic [1:0]         r_err;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_alu_acc;
    logic [4:0]         w_head_rd;
    logic [2:0]         w_head_f3;
    logic [1:0]         w_head_off;
    logic [15:0]        w_shifted;
    logic [31:0]        w_ld_data;
    logic               w_ld_bad;
    logic               w_win;
    logic [4:0]         w_win_rd;
    logic [31:0]        w_win_data;
    logic               w_skid_load;
    logic               w_skid_clear;
    logic               w_hazard;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_full_count);
    assign ld_ready  = !w_full;
    assign alu_ready = !r_skid_valid;
    assign w_push    = ld_issue && !w_full;
    assign w_pop     = mem_rvalid && !w_empty;
    assign w_alu_acc = alu_valid && !r_skid_valid;

    assign w_head_rd  = r_q_rd[r_rd_ptr];
    assign w_head_f3  = r_q_f3[r_rd_ptr];
    assign w_head_off = r_q_off[r_rd_ptr];

    // Only the low halfword of the shifted word is ever consumed
    assign w_shifted = 16'(mem_rdata >> {w_head_off, 3'b000});

    always_comb begin
        w_ld_data = mem_rdata;
        w_ld_bad  = 1'b0;
        case (w_head_f3)
            c_lb:    w_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            c_lbu:   w_ld_data = {24'd0, w_shifted[7:0]};
            c_lh:    begin
                w_ld_data = {{16{w_shifted[15]}}, w_shifted};
                w_ld_bad  = w_head_off[0];
            end
            c_lhu:   begin
                w_ld_data = {16'd0, w_shifted};
                w_ld_bad  = w_head_off[0];
            end
            c_lw:    w_ld_bad = (w_head_off != 2'd0);
            // Reserved encodings fall back to a full-word load
            default: w_ld_bad = 1'b1;
        endcase
    end

    // Priority: load response, then skid, then a freshly accepted ALU result
    always_comb begin
        w_win        = 1'b0;
        w_win_rd     = 5'd0;
        w_win_data   = 32'd0;
        w_skid_load  = 1'b0;
        w_skid_clear = 1'b0;
        if (w_pop) begin
            w_win       = 1'b1;
            w_win_rd    = w_head_rd;
            w_win_data  = w_ld_data;
            w_skid_load = w_alu_acc;
        end else if (r_skid_valid) begin
            w_win        = 1'b1;
            w_win_rd     = r_skid_rd;
            w_win_data   = r_skid_data;
            w_skid_clear = 1'b1;
        end else if (w_alu_acc) begin
            w_win      = 1'b1;
            w_win_rd   = alu_rd;
            w_win_data = alu_result;
        end
    end

    // Every occupied slot counts, including the head being popped this cycle
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < LDQ_DEPTH; i++) begin
            if (c_cnt_w'(i) < r_count) begin
                if ((r_q_rd[r_rd_ptr + c_ptr_w'(i)] != 5'd0) &&
                    ((r_q_rd[r_rd_ptr + c_ptr_w'(i)] == rs1) ||
                     (r_q_rd[r_rd_ptr + c_ptr_w'(i)] == rs2))) begin
                    w_hazard = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_q_rd[r_wr_ptr]  <= ld_rd;
            r_q_f3[r_wr_ptr]  <= ld_funct3;
            r_q_off[r_wr_ptr] <= ld_offset;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_skid_valid <= 1'b0;
            r_skid_rd    <= 5'd0;
            r_skid_data  <= 32'd0;
            r_regwrite   <= 1'b0;
            r_write_reg  <= 5'd0;
            r_write_data <= 32'd0;
            r_err        <= 2'b00;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_skid_load) begin
                r_skid_valid <= 1'b1;
                r_skid_rd    <= alu_rd;
                r_skid_data  <= alu_result;
            end else if (w_skid_clear) begin
                r_skid_valid <= 1'b0;
            end

            // Writes to x0 are consumed silently
            r_regwrite <= w_win && (w_win_rd != 5'd0);
            if (w_win && (w_win_rd != 5'd0)) begin
                r_write_reg  <= w_win_rd;
                r_write_data <= w_win_data;
            end

            if (mem_rvalid && w_empty) begin
                r_err[0] <= 1'b1;
            end
            if (w_pop && w_ld_bad) begin
                r_err[1] <= 1'b1;
            end
        end
    end

    assign hazard     = w_hazard;
    assign regwrite   = r_regwrite;
    assign write_reg  = r_write_reg;
    assign write_data = r_write_data;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_unit
// Description : Self-checking bench for writeback_unit: directed vector table,
//               a mid-operation reset sequence, and randomized traffic checked
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;

    localparam int c_depth = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_offset;
    logic        ld_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        hazard;
    logic        regwrite;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [1:0]  err;

    writeback_unit #(.LDQ_DEPTH(c_depth)) dut (
        .clock      (clock),
        .reset      (reset),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_result (alu_result),
        .alu_ready  (alu_ready),
        .ld_issue   (ld_issue),
        .ld_rd      (ld_rd),
        .ld_funct3  (ld_funct3),
        .ld_offset  (ld_offset),
        .ld_ready   (ld_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .rs1        (rs1),
        .rs2        (rs2),
        .hazard     (hazard),
        .regwrite   (regwrite),
        .write_reg  (write_reg),
        .write_data (write_data),
        .err        (err)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        av;   logic [4:0] ard;  logic [31:0] ares;
        logic        li;   logic [4:0] lrd;  logic [2:0]  lf3;  logic [1:0] loff;
        logic        rv;   logic [31:0] rdata;
        logic [4:0]  rs1;  logic [4:0] rs2;
        logic        e_ar; logic e_lr; logic e_hz;
        logic        e_rw; logic [4:0] e_wr; logic [31:0] e_wd; logic [1:0] e_err;
    } vec_t;

    typedef struct {
        logic [4:0] rd;
        logic [2:0] f3;
        logic [1:0] off;
    } ld_t;

    vec_t tbl [33];

    // Reference model state
    ld_t         mq [$];
    logic [4:0]  s_rd [$];
    logic [31:0] s_data [$];
    logic        m_rw;
    logic [4:0]  m_wr;
    logic [31:0] m_wd;
    logic [1:0]  m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        alu_valid = v.av;  alu_rd = v.ard;   alu_result = v.ares;
        ld_issue  = v.li;  ld_rd  = v.lrd;   ld_funct3  = v.lf3;  ld_offset = v.loff;
        mem_rvalid = v.rv; mem_rdata = v.rdata;
        rs1 = v.rs1; rs2 = v.rs2;
        #1;
        chk({tag, "_alu_ready"}, alu_ready, v.e_ar);
        chk({tag, "_ld_ready"},  ld_ready,  v.e_lr);
        chk({tag, "_hazard"},    hazard,    v.e_hz);
        @(posedge clock);
        #1;
        chk({tag, "_regwrite"},   regwrite,   v.e_rw);
        chk({tag, "_write_reg"},  write_reg,  v.e_wr);
        chk({tag, "_write_data"}, write_data, v.e_wd);
        chk({tag, "_err"},        err,        v.e_err);
    endtask

    task automatic idle_inputs();
        alu_valid = 0; alu_rd = 0; alu_result = 0;
        ld_issue = 0; ld_rd = 0; ld_funct3 = 0; ld_offset = 0;
        mem_rvalid = 0; mem_rdata = 0; rs1 = 0; rs2 = 0;
    endtask

    // Load result from the load-type rules, in plain arithmetic
    function automatic logic [31:0] fmt(input logic [2:0] f3, input logic [1:0] off,
                                        input logic [31:0] d);
        longint unsigned sh;
        longint          v;
        sh = d;
        sh = sh >> (8 * int'(off));
        case (f3)
            3'd0:    begin v = longint'(sh % 256);   if (v >= 128)   v = v - 256;   end
            3'd4:    v = longint'(sh % 256);
            3'd1:    begin v = longint'(sh % 65536); if (v >= 32768) v = v - 65536; end
            3'd5:    v = longint'(sh % 65536);
            default: v = longint'(d);
        endcase
        return v[31:0];
    endfunction

    function automatic bit is_bad(input logic [2:0] f3, input logic [1:0] off);
        return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
               (((f3 == 3'd1) || (f3 == 3'd5)) && off[0]) ||
               ((f3 == 3'd2) && (off != 2'd0));
    endfunction

    task automatic rand_cycle(input int n);
        bit          push, win, acc, hz;
        logic [4:0]  wrd;
        logic [31:0] wd;
        ld_t         h;
        ld_t         nl;
        alu_valid  = ($urandom_range(0, 1) == 1);
        alu_rd     = 5'($urandom_range(0, 31));
        alu_result = $urandom;
        ld_issue   = ($urandom_range(0, 9) < 4);
        ld_rd      = 5'($urandom_range(0, 7));
        ld_funct3  = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 5));
        ld_offset  = 2'($urandom_range(0, 3));
        mem_rvalid = (mq.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0);
        mem_rdata  = $urandom;
        rs1        = 5'($urandom_range(0, 7));
        rs2        = 5'($urandom_range(0, 7));
        #1;
        hz = 0;
        foreach (mq[k]) if (mq[k].rd != 0 && (mq[k].rd == rs1 || mq[k].rd == rs2)) hz = 1;
        chk($sformatf("rnd%0d_alu_ready", n), alu_ready, s_rd.size() == 0);
        chk($sformatf("rnd%0d_ld_ready", n),  ld_ready,  mq.size() < c_depth);
        chk($sformatf("rnd%0d_hazard", n),    hazard,    hz);
        push = ld_issue && (mq.size() < c_depth);
        acc  = alu_valid && (s_rd.size() == 0);
        win = 0; wrd = 0; wd = 0;
        if (mem_rvalid && mq.size() > 0) begin
            h   = mq.pop_front();
            win = 1; wrd = h.rd; wd = fmt(h.f3, h.off, mem_rdata);
            if (is_bad(h.f3, h.off)) m_err[1] = 1'b1;
            if (acc) begin s_rd.push_back(alu_rd); s_data.push_back(alu_result); end
        end else begin
            if (mem_rvalid) m_err[0] = 1'b1;
            if (s_rd.size() > 0) begin
                win = 1; wrd = s_rd.pop_front(); wd = s_data.pop_front();
            end else if (acc) begin
                win = 1; wrd = alu_rd; wd = alu_result;
            end
        end
        if (push) begin
            nl.rd = ld_rd; nl.f3 = ld_funct3; nl.off = ld_offset;
            mq.push_back(nl);
        end
        m_rw = win && (wrd != 0);
        if (m_rw) begin m_wr = wrd; m_wd = wd; end
        @(posedge clock);
        #1;
        chk($sformatf("rnd%0d_regwrite", n),   regwrite,   m_rw);
        chk($sformatf("rnd%0d_write_reg", n),  write_reg,  m_wr);
        chk($sformatf("rnd%0d_write_data", n), write_data, m_wd);
        chk($sformatf("rnd%0d_err", n),        err,        m_err);
    endtask

    initial begin
        //         av ard ares        li lrd f3 off rv rdata          rs1 rs2 ar lr hz rw wr wd            err
        tbl[0]  = '{0, 0, 0,           0, 0, 0, 0,  0, 0,             0,  0,  1, 1, 0, 0, 0, 0,             0};
        tbl[1]  = '{1, 5, 7,           0, 0, 0, 0,  0, 0,             0,  0,  1, 1, 0, 1, 5, 7,             0};
        tbl[2]  = '{0, 0, 0,           0, 0, 0, 0,  0, 0,             0,  0,  1, 1, 0, 0, 5, 7,             0};
        tbl[3]  = '{0, 0, 0,           1, 9, 0, 2,  0, 0,             0,  0,  1, 1, 0, 0, 5, 7,             0};
        tbl[4]  = '{0, 0, 0,           0, 0, 0, 0,  1, 32'h12F34455,  9,  0,  1, 1, 1, 1, 9, 32'hFFFFFFF3,  0};
        tbl[5]  = '{0, 0, 0,           1, 10, 5, 2, 0, 0,             0,  0,  1, 1, 0, 0, 9, 32'hFFFFFFF3,  0};
        tbl[6]  = '{0, 0, 0,           0, 0, 0, 0,  1, 32'h12F34455,  0,  10, 1, 1, 1, 1, 10, 32'h000012F3, 0};
        tbl[7]  = '{0, 0, 0,           1, 8, 2, 0,  0, 0,             0,  0,  1, 1, 0, 0, 10, 32'h000012F3, 0};
        tbl[8]  = '{1, 6, 3,           0, 0, 0, 0,  1, 32'hA5A5A5A5,  0,  0,  1, 1, 0, 1, 8, 32'hA5A5A5A5,  0};
        tbl[9]  = '{0, 0, 0,           0, 0, 0, 0,  0, 0,             0,  0,  0, 1, 0, 1, 6, 3,             0};
        tbl[10] = '{0, 0, 0,           0, 0, 0, 0,  0, 0,             0,  0,  1, 1, 0, 0, 6, 3,             0};
        tbl[11] = '{0, 0, 0,           1, 3, 2, 0,  0, 0,             0,  0,  1, 1, 0, 0, 6, 3,             0};
        tbl[12] = '{0, 0, 0,           1, 4, 2, 0,  0, 0,             4,  0,  1, 1, 0, 0, 6, 3,             0};
        tbl[13] = '{0, 0, 0,           0, 0, 0, 0,  0, 0,             4,  0,  1, 0, 1, 0, 6, 3,             0};
        tbl[14] = '{0, 0, 0,           0, 0, 0, 0,  1, 32'h11111111,  4,  0,  1, 0, 1, 1, 3, 32'h11111111,  0};
        tbl[15] = '{0, 0, 0,           0, 0, 0, 0,  0, 0,             4,  0,  1, 1, 1, 0, 3, 32'h11111111,  0};
        tbl[16] = '{0, 0, 0,           0, 0, 0, 0,  1, 32'h22222222,  4,  0,  1, 1, 1, 1, 4, 32'h22222222,  0};
        tbl[17] = '{0, 0, 0,           0, 0, 0, 0,  0, 0,             4,  0,  1, 1, 0, 0, 4, 32'h22222222,  0};
        tbl[18] = '{0, 0, 0,           0, 0, 0, 0,  1, 32'hDEADBEEF,  0,  0,  1, 1, 0, 0, 4, 32'h22222222,  1};
        tbl[19] = '{0, 0, 0,           1, 7, 2, 1,  0, 0,             0,  0,  1, 1, 0, 0, 4, 32'h22222222,  1};
        tbl[20] = '{0, 0, 0,           0, 0, 0, 0,  1, 32'h33333333,  0,  0,  1, 1, 0, 1, 7, 32'h33333333,  3};
        tbl[21] = '{1, 0, 32'h55,      0, 0, 0, 0,  0, 0,             0,  0,  1, 1, 0, 0, 7, 32'h33333333,  3};
        tbl[22] = '{0, 0, 0,           1, 0, 0, 0,  0, 0,             0,  0,  1, 1, 0, 0, 7, 32'h33333333,  3};
        tbl[23] = '{0, 0, 0,           0, 0, 0, 0,  1, 32'h00000080,  0,  0,  1, 1, 0, 0, 7, 32'h33333333,  3};
        tbl[24] = '{0, 0, 0,           1, 11, 1, 0, 0, 0,             0,  0,  1, 1, 0, 0, 7, 32'h33333333,  3};
        tbl[25] = '{0, 0, 0,           0, 0, 0, 0,  1, 32'h00008001,  0,  0,  1, 1, 0, 1, 11, 32'hFFFF8001, 3};
        tbl[26] = '{0, 0, 0,           1, 12, 2, 0, 0, 0,             0,  0,  1, 1, 0, 0, 11, 32'hFFFF8001, 3};
        tbl[27] = '{0, 0, 0,           1, 13, 2, 0, 0, 0,             0,  0,  1, 1, 0, 0, 11, 32'hFFFF8001, 3};
        tbl[28] = '{1, 14, 32'hE,      1, 20, 2, 0, 1, 32'hC,         20, 0,  1, 0, 0, 1, 12, 32'hC,        3};
        tbl[29] = '{1, 15, 32'hF,      0, 0, 0, 0,  1, 32'hD,         20, 13, 0, 1, 1, 1, 13, 32'hD,        3};
        tbl[30] = '{1, 15, 32'hF,      0, 0, 0, 0,  0, 0,             20, 0,  0, 1, 0, 1, 14, 32'hE,        3};
        tbl[31] = '{1, 15, 32'hF,      0, 0, 0, 0,  0, 0,             0,  0,  1, 1, 0, 1, 15, 32'hF,        3};
        tbl[32] = '{0, 0, 0,           0, 0, 0, 0,  0, 0,             0,  0,  1, 1, 0, 0, 15, 32'hF,        3};

        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_regwrite", regwrite, 0);
        chk("rst_write_reg", write_reg, 0);
        chk("rst_write_data", write_data, 0);
        chk("rst_err", err, 0);
        chk("rst_alu_ready", alu_ready, 1);
        chk("rst_ld_ready", ld_ready, 1);
        chk("rst_hazard", hazard, 0);
        reset = 1'b1;

        for (int i = 0; i < 33; i++) apply(tbl[i], $sformatf("vec%0d", i));

        // Reset while a load is pending and the skid is occupied
        apply('{0, 0, 0,      1, 21, 2, 0, 0, 0,        0,  0, 1, 1, 0, 0, 15, 32'hF,  3}, "mr_a");
        apply('{1, 22, 32'h16, 1, 23, 2, 0, 1, 32'h15,  0,  0, 1, 1, 0, 1, 21, 32'h15, 3}, "mr_b");
        reset = 1'b0;
        apply('{0, 0, 0,      0, 0, 0, 0,  0, 0,        23, 0, 0, 1, 1, 0, 0, 0,       0}, "mr_rst");
        reset = 1'b1;
        apply('{0, 0, 0,      0, 0, 0, 0,  0, 0,        23, 0, 1, 1, 0, 0, 0, 0,       0}, "mr_after");
        apply('{0, 0, 0,      0, 0, 0, 0,  1, 32'h99,   0,  0, 1, 1, 0, 0, 0, 0,       1}, "mr_orphan");

        // Randomized traffic against the reference model
        idle_inputs();
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        mq.delete(); s_rd.delete(); s_data.delete();
        m_rw = 0; m_wr = 0; m_wd = 0; m_err = 0;
        for (int n = 0; n < 2000; n++) rand_cycle(n);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Writer side of the register file: gathers ALU results and returning data-memory loads, then drives the single register-file write port (regwrite, write_reg, write_data).
- Tracks outstanding loads in a small in-order queue and formats load data by funct3 and byte offset.
- Arbitrates between the ALU and memory paths and flags read-after-load hazards back to decode.

Parameters:
- LDQ_DEPTH, 2, number of outstanding loads tracked; power of two, minimum 2.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- alu_valid  input  1  ALU result present this cycle.
- alu_rd  input  5  ALU destination register.
- alu_result  input  32  ALU result value.
- alu_ready  output  1  ALU result accepted when alu_valid && alu_ready.
- ld_issue  input  1  load issued to data memory this cycle.
- ld_rd  input  5  load destination register.
- ld_funct3  input  3  load type.
- ld_offset  input  2  byte address bits [1:0] of the load.
- ld_ready  output  1  load queue can accept ld_issue.
- mem_rvalid  input  1  memory read data valid; responses return in issue order.
- mem_rdata  input  32  aligned 32-bit memory word.
- rs1  input  5  decode source register 1, for the hazard check.
- rs2  input  5  decode source register 2, for the hazard check.
- hazard  output  1  rs1 or rs2 matches a pending load destination.
- regwrite  output  1  register-file write enable.
- write_reg  output  5  register-file write address.
- write_data  output  32  register-file write data.
- err  output  2  sticky flags: bit0 = response with empty queue; bit1 = illegal funct3 or misaligned load.

Behaviour:
- Reset (reset==0 at a clock edge):
  - regwrite=0, write_reg=0, write_data=0, err=0.
  - Load queue empty; skid buffer empty.
  - After reset, alu_ready=1 and ld_ready=1.
- Load queue:
  - Circular FIFO of {rd, funct3, offset} with LDQ_DEPTH entries.
  - Push on ld_issue && ld_ready.
  - ld_ready = !full. No push-on-pop when full: ld_ready stays 0 even if mem_rvalid pops in the same cycle.
  - Pop on mem_rvalid && !empty. Push and pop in the same cycle when neither full nor empty leaves the count unchanged.
  - Pointers wrap modulo LDQ_DEPTH.
  - mem_rvalid while empty is ignored (no write) and sets err[0].
- Load formatting (head entry, combinational): sh = mem_rdata >> (8*offset).
  - 000 LB: sign-extend sh[7:0].
  - 100 LBU: zero-extend sh[7:0].
  - 001 LH: sign-extend sh[15:0].
  - 101 LHU: zero-extend sh[15:0].
  - 010 LW: mem_rdata, offset ignored.
  - Misaligned cases: LH/LHU with offset[0]=1, or LW with offset!=0. These still write the value above and set err[1].
  - Funct3 011/110/111 is treated as LW and sets err[1].
- Write arbitration, evaluated each cycle, highest priority first:
  - (1) load response: mem_rvalid && !empty.
  - (2) skid buffer entry.
  - (3) accepted ALU result.
  - alu_ready = skid empty.
  - An accepted ALU result that loses arbitration is stored in the skid. It is written on the first later cycle with no load response.
  - While the skid is occupied, alu_ready=0.
  - The skid and a live ALU result never coexist, because alu_ready gates acceptance.
- Output timing:
  - The winning write appears on regwrite/write_reg/write_data at the next rising edge (1-cycle latency).
  - regwrite=1 for exactly one cycle per write.
  - regwrite=0 in cycles with no winner. write_reg/write_data hold their last values when regwrite=0.
- x0 rule: a winner with rd==0 is consumed (popped / skid cleared) but produces regwrite=0.
- Hazard (combinational): hazard=1 iff some valid queue entry has rd!=0 and rd==rs1 or rd==rs2. The entry being popped this cycle still counts.
- Reset mid-operation:
  - Pending loads and the skid entry are discarded with no write.
  - Responses arriving after reset set err[0].
- err bits stay set until reset.

Test Plan:
- Reset then idle: regwrite=0, write_reg=0, write_data=0, err=0, alu_ready=1, ld_ready=1, hazard=0.
- ALU write: alu_valid=1, alu_rd=5, alu_result=32'h0000_0007 at cycle N -> regwrite=1, write_reg=5, write_data=7 at N+1 only.
- Load formatting:
  - Issue LB rd=9 offset=2; respond mem_rdata=32'h12F3_4455 -> write_data=32'hFFFF_FFF3 to x9.
  - Issue LHU offset=2 on the same word -> write_data=32'h0000_12F3.
- Collision: load response (rd=8, LW, data 32'hA5A5_A5A5) and ALU (rd=6, 3) in the same cycle -> x8 written at N+1, x6 at N+2; alu_ready=0 during N+1.
- Queue and hazard:
  - Issue 2 loads (rd=3, rd=4) with no response -> ld_ready=0; with rs1=4, hazard=1.
  - One response -> ld_ready=1 next cycle; hazard still 1 until x4's response.
- Errors and x0:
  - mem_rvalid with empty queue -> no write, err=2'b01.
  - LW offset=1 -> err[1] set.
  - ALU rd=0 -> regwrite stays 0.
